serial_subtractor: RTL

- Bit-serial unsigned subtractor. Computes D = A - B over WIDTH clock cycles, LSB first.
- Uses a one-bit difference/borrow cell and a registered borrow, so cost stays small on wide operands.
- Companion to the combinational adder cells in the arithmetic lab set; exercises the subtract direction.
- Controlled by a start/busy/done handshake, so a testbench or lab controller FSM can drive it.

---
 rtl/serial_subtractor.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial unsigned subtractor. Computes D = A - B one bit per clock,
//   LSB first. It uses a one-bit difference/borrow cell and a registered
//   borrow, so the datapath stays small for wide operands. A start/busy/done
//   handshake drives one operation at a time.
//
//   state | meaning
//   IDLE  | waiting for start; D/Bout hold the last result
//   RUN   | one bit of A - B processed per edge, WIDTH edges in total
//   DONE  | done=1 for this one cycle; returns to IDLE unconditionally
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous reset, active-high; has priority over start
//   start in   request one subtraction, sampled only in IDLE
//   A     in   minuend, captured on the accepting edge
//   B     in   subtrahend, captured on the accepting edge
//   busy  out  high whenever the state is not IDLE
//   done  out  one-cycle pulse when D/Bout carry a new result
//   D     out  (A - B) mod 2^WIDTH, held until the next completion
//   Bout  out  final borrow, 1 iff A < B (unsigned)
//   OVF   out  two's-complement overflow of A - B
//              (present only when SERIAL_SUB_OVF_EN is defined)
//
// Optional feature macro: SERIAL_SUB_OVF_EN

module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
`ifdef SERIAL_SUB_OVF_EN
    output logic             Bout,
    output logic             OVF
`else
    output logic             Bout
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ra_q;
    logic [WIDTH-1:0] rb_q;
    logic [WIDTH-1:0] res_q;
    logic             br_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dout_q;
    logic             bout_q;

    // One-bit difference/borrow cell on the current LSBs.
    logic             bit_d;
    logic             br_d;
    logic [WIDTH-1:0] res_d;

    assign bit_d = ra_q[0] ^ rb_q[0] ^ br_q;
    assign br_d  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
    assign res_d = {bit_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUB_OVF_EN
    logic ovf_q;
    // At the MSB step br_q is the borrow into the MSB and br_d the borrow out.
    logic ovf_d;
    assign ovf_d = br_q ^ br_d;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        ra_q    <= A;
                        rb_q    <= B;
                        res_q   <= '0;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    ra_q  <= ra_q >> 1;
                    rb_q  <= rb_q >> 1;
                    res_q <= res_d;
                    br_q  <= br_d;
                    cnt_q <= cnt_q + 1'b1;
                    // The last bit is folded into D on the same edge it is computed.
                    if (cnt_q == LAST_BIT) begin
                        dout_q  <= res_d;
                        bout_q  <= br_d;
`ifdef SERIAL_SUB_OVF_EN
                        ovf_q   <= ovf_d;
`endif
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign D    = dout_q;
    assign Bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule
